// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared definitions for the next-PC unit.
//            - FSM state enum (BOOT, RUN, HALTED)
//            - next-PC source select encoding
//            - default reset and exception vectors
//            - helper that classifies a select as a redirect
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam logic [31:0] PC_DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_DEFAULT_EXC_VECTOR   = 32'h8000_0180;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

    // SEL_HOLD keeps pc_out unchanged (boot, stall, halt without redirect).
    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_SEQ    = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_JR     = 3'd4,
        SEL_EXC    = 3'd5
    } pc_sel_e;

    // A redirect is any non-sequential change of flow; it triggers a flush.
    function automatic logic is_redirect(input pc_sel_e sel);
        return (sel == SEL_BRANCH) || (sel == SEL_JUMP) ||
               (sel == SEL_JR)     || (sel == SEL_EXC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_adder.sv
`default_nettype none
// ============================================================================
// Module   : pc_adder
// Purpose  : Plain ADDR_W-bit wrapping adder (no carry out).
// Ports    : a, b  - addends
//            sum   - (a + b) mod 2^ADDR_W
// Revision : 1.0 - initial release
// ============================================================================
module pc_adder #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] b,
    output logic [ADDR_W-1:0] sum
);

    assign sum = a + b;

endmodule
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_unit
// Purpose  : Program-counter sequencer. Selects the next fetch address from
//            sequential / branch / jump / register / exception sources with
//            fixed priority, and tracks a BOOT -> RUN -> HALTED state machine.
// Config   : `define PC_EXC_EN adds the exc_req port and the exception path
//            (EXC_VECTOR target, exit from HALTED). Undefined by default.
// Ports    : clock, reset_n (sync, active-low)
//            stall                      - freeze all state
//            branch_taken/branch_offset - PC-relative word-offset branch
//            jump/jump_index            - region-absolute jump
//            jump_reg/jr_addr           - register-indirect jump
//            halt                       - enter HALTED
//            exc_req                    - exception (PC_EXC_EN only)
//            pc_out                     - registered fetch address
//            pc_plus_inc                - pc_out + INC (combinational)
//            fetch_valid                - pc_out is valid (RUN only)
//            flush                      - one cycle after an accepted redirect
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_unit
    import pc_pkg::*;
#(
    // ADDR_W must be at least 28 (jump target keeps pc_plus_inc[ADDR_W-1:28]).
    parameter int                ADDR_W       = 32,
    parameter int                INC          = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_DEFAULT_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(PC_DEFAULT_EXC_VECTOR)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              jump_reg,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              halt,
`ifdef PC_EXC_EN
    input  logic              exc_req,
`endif
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus_inc,
    output logic              fetch_valid,
    output logic              flush
);

    localparam logic [ADDR_W-1:0] INC_VALUE = ADDR_W'(INC);

    pc_state_e         state;
    pc_state_e         next_state;
    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;

    // ------------------------------------------------------------------
    // Target arithmetic
    // ------------------------------------------------------------------
    pc_adder #(.ADDR_W(ADDR_W)) u_inc_adder (
        .a   (pc_out),
        .b   (INC_VALUE),
        .sum (pc_plus_inc)
    );

    pc_adder #(.ADDR_W(ADDR_W)) u_branch_adder (
        .a   (pc_plus_inc),
        .b   (branch_offset << 2),
        .sum (branch_target)
    );

    // The jump keeps the region bits of the incremented PC above bit 27.
    if (ADDR_W > 28) begin : g_jump_wide
        assign jump_target = {pc_plus_inc[ADDR_W-1:28], jump_index, 2'b00};
    end else begin : g_jump_narrow
        assign jump_target = {jump_index, 2'b00};
    end

`ifndef PC_EXC_EN
    // Exception vector has no consumer in this build.
    logic unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    // ------------------------------------------------------------------
    // Next-state / select logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        sel        = SEL_HOLD;

        case (state)
            BOOT: begin
                next_state = RUN;
            end

            RUN: begin
`ifdef PC_EXC_EN
                if (exc_req) begin
                    sel = SEL_EXC;
                end else
`endif
                if (jump_reg) begin
                    sel = SEL_JR;
                end else if (jump) begin
                    sel = SEL_JUMP;
                end else if (branch_taken) begin
                    sel = SEL_BRANCH;
                end else if (!halt) begin
                    sel = SEL_SEQ;
                end
                // A redirect in the halting cycle still lands before HALTED.
                if (halt) begin
                    next_state = HALTED;
                end
            end

            HALTED: begin
`ifdef PC_EXC_EN
                if (exc_req) begin
                    sel        = SEL_EXC;
                    next_state = RUN;
                end
`endif
            end

            default: begin
                next_state = BOOT;
            end
        endcase

        // Stall overrides everything except reset.
        if (stall) begin
            next_state = state;
            sel        = SEL_HOLD;
        end
    end

    always_comb begin
        pc_next = pc_out;
        case (sel)
            SEL_SEQ:    pc_next = pc_plus_inc;
            SEL_BRANCH: pc_next = branch_target;
            SEL_JUMP:   pc_next = jump_target;
            SEL_JR:     pc_next = jr_addr;
`ifdef PC_EXC_EN
            SEL_EXC:    pc_next = EXC_VECTOR;
`endif
            default:    pc_next = pc_out;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= BOOT;
            pc_out <= RESET_VECTOR;
            flush  <= 1'b0;
        end else begin
            state  <= next_state;
            pc_out <= pc_next;
            flush  <= is_redirect(sel);
        end
    end

    assign fetch_valid = (state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_next_unit
// Purpose  : Self-checking bench for pc_next_unit (default parameters).
//            Driver applies directed then random stimulus and pushes the
//            expected post-edge outputs into a queue; a monitor pops and
//            compares one entry per clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;

`ifdef PC_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] EXV = 32'h8000_0180;

    localparam int MODE_BOOT   = 0;
    localparam int MODE_RUN    = 1;
    localparam int MODE_HALTED = 2;

    logic        clock = 1'b0;
    logic        reset_n, stall, branch_taken, jump, jump_reg, halt, exc_req;
    logic [31:0] branch_offset, jr_addr;
    logic [25:0] jump_index;
    logic [31:0] pc_out, pc_plus_inc;
    logic        fetch_valid, flush;

    pc_next_unit dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jr_addr       (jr_addr),
        .halt          (halt),
`ifdef PC_EXC_EN
        .exc_req       (exc_req),
`endif
        .pc_out        (pc_out),
        .pc_plus_inc   (pc_plus_inc),
        .fetch_valid   (fetch_valid),
        .flush         (flush)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rn, st, bt;
        logic [31:0] bo;
        logic        j;
        logic [25:0] ji;
        logic        jr;
        logic [31:0] ja;
        logic        h, ex;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic        fv, fl;
        bit          chk;
        logic [31:0] cpc;
        logic        cfv, cfl;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int          m_mode = MODE_BOOT;
    logic [31:0] m_pc   = RV;
    logic        m_fl   = 1'b0;

    function automatic stim_t idle();
        stim_t s;
        s.rn = 1'b1; s.st = 1'b0; s.bt = 1'b0; s.bo = '0; s.j = 1'b0;
        s.ji = '0;   s.jr = 1'b0; s.ja = '0;   s.h = 1'b0; s.ex = 1'b0;
        return s;
    endfunction

    // Spec-level next-PC model.
    task automatic model(input stim_t s);
        logic [31:0] ppi;
        logic        ex;
        logic        redir;
        ex    = s.ex & EXC_EN;
        redir = 1'b0;
        if (!s.rn) begin
            m_pc = RV; m_mode = MODE_BOOT; m_fl = 1'b0;
        end else if (s.st) begin
            m_fl = 1'b0;
        end else if (m_mode == MODE_BOOT) begin
            m_mode = MODE_RUN; m_fl = 1'b0;
        end else if (m_mode == MODE_RUN) begin
            ppi = m_pc + 32'd4;
            redir = ex | s.jr | s.j | s.bt;
            if (ex)        m_pc = EXV;
            else if (s.jr) m_pc = s.ja;
            else if (s.j)  m_pc = {ppi[31:28], s.ji, 2'b00};
            else if (s.bt) m_pc = ppi + (s.bo * 32'd4);
            else if (!s.h) m_pc = ppi;
            m_fl = redir;
            if (s.h) m_mode = MODE_HALTED;
        end else begin
            m_fl = 1'b0;
            if (ex) begin
                m_pc = EXV; m_mode = MODE_RUN; m_fl = 1'b1;
            end
        end
    endtask

    task automatic step(input stim_t s, input bit chk, input logic [31:0] cpc,
                        input logic cfv, input logic cfl, input string name);
        exp_t e;
        @(negedge clock);
        reset_n = s.rn; stall = s.st; branch_taken = s.bt; branch_offset = s.bo;
        jump = s.j; jump_index = s.ji; jump_reg = s.jr; jr_addr = s.ja;
        halt = s.h; exc_req = s.ex & EXC_EN;
        model(s);
        e.pc = m_pc; e.fv = (m_mode == MODE_RUN); e.fl = m_fl;
        e.chk = chk; e.cpc = cpc; e.cfv = cfv; e.cfl = cfl; e.name = name;
        exp_q.push_back(e);
        @(posedge clock);
        #2;
    endtask

    task automatic run(input stim_t s);
        step(s, 1'b0, '0, 1'b0, 1'b0, "");
    endtask

    // Monitor / scoreboard
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (pc_out !== e.pc || fetch_valid !== e.fv || flush !== e.fl ||
                pc_plus_inc !== (e.pc + 32'd4)) begin
                n_err++;
                $display("FAIL model t=%0t: pc=%h fv=%b fl=%b ppi=%h, required pc=%h fv=%b fl=%b ppi=%h",
                         $time, pc_out, fetch_valid, flush, pc_plus_inc,
                         e.pc, e.fv, e.fl, e.pc + 32'd4);
            end
            if (e.chk) begin
                n_vec++;
                if (pc_out !== e.cpc || fetch_valid !== e.cfv || flush !== e.cfl) begin
                    n_err++;
                    $display("FAIL %s: pc=%h fv=%b fl=%b, required pc=%h fv=%b fl=%b",
                             e.name, pc_out, fetch_valid, flush, e.cpc, e.cfv, e.cfl);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        logic [31:0] t;

        s = idle(); s.rn = 1'b0;
        reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_index = '0; jump_reg = 1'b0; jr_addr = '0;
        halt = 1'b0; exc_req = 1'b0;

        // Reset and boot
        run(s);
        step(s, 1'b1, 32'h0, 1'b0, 1'b0, "reset_boot");
        s = idle();
        step(s, 1'b1, 32'h0, 1'b1, 1'b0, "run_pc0");
        step(s, 1'b1, 32'h4, 1'b1, 1'b0, "run_pc4");
        step(s, 1'b1, 32'h8, 1'b1, 1'b0, "run_pc8");

        // Backward branch
        s = idle(); s.jr = 1'b1; s.ja = 32'h10;
        step(s, 1'b1, 32'h10, 1'b1, 1'b1, "jr_to_10");
        s = idle(); s.bt = 1'b1; s.bo = 32'hFFFF_FFFC;
        step(s, 1'b1, 32'h4, 1'b1, 1'b1, "branch_back");
        s = idle();
        step(s, 1'b1, 32'h8, 1'b1, 1'b0, "flush_one_cycle");

        // Jump wins over branch
        s = idle(); s.jr = 1'b1; s.ja = 32'h1000_0000;
        run(s);
        s = idle(); s.j = 1'b1; s.bt = 1'b1; s.bo = 32'h8; s.ji = 26'h40;
        step(s, 1'b1, 32'h1000_0100, 1'b1, 1'b1, "jump_over_branch");

        // Stall ignores redirect
        s = idle(); s.st = 1'b1; s.jr = 1'b1; s.ja = 32'h400;
        for (int i = 0; i < 3; i++)
            step(s, 1'b1, 32'h1000_0100, 1'b1, 1'b0, "stall_hold");
        s.st = 1'b0;
        step(s, 1'b1, 32'h400, 1'b1, 1'b1, "jr_after_stall");

        // Wrap at top of address space
        s = idle(); s.jr = 1'b1; s.ja = 32'hFFFF_FFFC;
        run(s);
        s = idle();
        step(s, 1'b1, 32'h0, 1'b1, 1'b0, "seq_wrap");

        // Halt
        s = idle(); s.jr = 1'b1; s.ja = 32'h20;
        run(s);
        s = idle(); s.h = 1'b1;
        step(s, 1'b1, 32'h20, 1'b0, 1'b0, "halt_enter");
        s = idle();
        step(s, 1'b1, 32'h20, 1'b0, 1'b0, "halt_hold");
        if (EXC_EN) begin
            s = idle(); s.ex = 1'b1;
            step(s, 1'b1, EXV, 1'b1, 1'b1, "exc_from_halt");
        end
        s = idle(); s.rn = 1'b0;
        step(s, 1'b1, 32'h0, 1'b0, 1'b0, "reset_after_halt");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s.rn = ($urandom_range(0, 99) >= 2);
            s.st = ($urandom_range(0, 99) < 20);
            s.bt = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 1) == 0) begin
                s.bo = $urandom;
            end else begin
                t = $urandom_range(0, 64);
                s.bo = t - 32'd32;
            end
            s.j  = ($urandom_range(0, 99) < 10);
            s.ji = 26'($urandom);
            s.jr = ($urandom_range(0, 99) < 8);
            s.ja = $urandom;
            s.h  = ($urandom_range(0, 99) < 4);
            s.ex = ($urandom_range(0, 99) < 4);
            run(s);
        end

        repeat (3) @(posedge clock);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
